mag_rr_scheduler: RTL

- Shares one pipelined complex-magnitude datapath (real^2 + imag^2, fixed-point) among NUM_REQ requesters, e.g. per-antenna channel-estimate streams in the MIMO-OFDM receiver.
- A round-robin arbiter grants one requester per cycle.
- Each result leaves tagged with the granted requester ID.
- Backpressure on the result port stalls the whole pipeline, so no data is lost.

---
 rtl/mag_rr_scheduler_pkg.sv | 17 +
 rtl/mag_sq_pipe.sv | 60 ++++++
 rtl/mag_rr_scheduler.sv | 79 +++++++
 3 files changed

// File: rtl/mag_rr_scheduler_pkg.sv
// Shared fixed-point sizing and helpers for the magnitude-squared scheduler.
// Requester i occupies bits [i*W +: W] of every packed request bus.
`ifndef FIXED_POINT_WIDTH
`define FIXED_POINT_WIDTH 16
`endif
`ifndef FRACTION_BITS
`define FRACTION_BITS 8
`endif

package mag_rr_scheduler_pkg;
  localparam int W    = `FIXED_POINT_WIDTH;
  localparam int FRAC = `FRACTION_BITS;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage real^2 + imag^2 datapath with an ID tag, stall enable and flush.
module mag_sq_pipe
  import mag_rr_scheduler_pkg::*;
#(
  parameter int DW  = W,
  parameter int FB  = FRAC,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           flush_i,
  input  logic           in_valid_i,
  input  logic [DW-1:0]  in_re_i,
  input  logic [DW-1:0]  in_im_i,
  input  logic [IDW-1:0] in_id_i,
  output logic           s1_valid_o,
  output logic           out_valid_o,
  output logic [DW-1:0]  out_data_o,
  output logic [IDW-1:0] out_id_o
);
  logic [2:1]             vld_pipe_q;
  logic signed [2*DW-1:0] re_sq_q, im_sq_q;
  logic [IDW-1:0]         id1_q, id2_q;
  logic [DW-1:0]          data_q;
  logic signed [2*DW:0]   sum;

  assign sum = {re_sq_q[2*DW-1], re_sq_q} + {im_sq_q[2*DW-1], im_sq_q};

  // Data registers load only with a valid entry, so the output word holds
  // across bubbles and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
      id1_q      <= '0;
      id2_q      <= '0;
      data_q     <= '0;
    end else if (flush_i) begin
      vld_pipe_q <= '0;
    end else if (en_i) begin
      vld_pipe_q <= {vld_pipe_q[1], in_valid_i};
      if (in_valid_i) begin
        re_sq_q <= $signed(in_re_i) * $signed(in_re_i);
        im_sq_q <= $signed(in_im_i) * $signed(in_im_i);
        id1_q   <= in_id_i;
      end
      if (vld_pipe_q[1]) begin
        data_q <= DW'(sum >> FB);
        id2_q  <= id1_q;
      end
    end
  end

  assign s1_valid_o  = vld_pipe_q[1];
  assign out_valid_o = vld_pipe_q[2];
  assign out_data_o  = data_q;
  assign out_id_o    = id2_q;
endmodule

// File: rtl/mag_rr_scheduler.sv
// Round-robin front end sharing one mag_sq_pipe among NUM_REQ requesters;
// results leave tagged with the granted requester index.
module mag_rr_scheduler
  import mag_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = `FIXED_POINT_WIDTH,
  parameter int FRAC    = `FRACTION_BITS,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_real,
  input  logic [NUM_REQ*W-1:0] req_imag,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  output logic [W-1:0]         res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready,
  output logic                 busy
);
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_idx;
  logic [W-1:0]   sel_re, sel_im;
  logic           found, advance, grant_ok, s1_valid;
  int             idx;

  assign advance = !(res_valid && !res_ready);

  // Search starts one past the last winner, so the last winner ranks lowest.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sel_re    = '0;
    sel_im    = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
        sel_re    = req_real[idx*W +: W];
        sel_im    = req_imag[idx*W +: W];
      end
    end
  end

  always_comb begin
    grant_ok  = found && advance && !clear && rst_n;
    req_ready = grant_ok ? (NUM_REQ'(1) << grant_idx) : '0;
    ptr_d     = ptr_q;
    if (clear)         ptr_d = IDW'(NUM_REQ - 1);
    else if (grant_ok) ptr_d = grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDW'(NUM_REQ - 1);
    else        ptr_q <= ptr_d;
  end

  mag_sq_pipe #(.DW(W), .FB(FRAC), .IDW(IDW)) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (advance),
    .flush_i    (clear),
    .in_valid_i (grant_ok),
    .in_re_i    (sel_re),
    .in_im_i    (sel_im),
    .in_id_i    (grant_idx),
    .s1_valid_o (s1_valid),
    .out_valid_o(res_valid),
    .out_data_o (res_data),
    .out_id_o   (res_id)
  );

  assign busy = s1_valid | res_valid;
endmodule
